// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn controller.
package ttt_pkg;

    localparam logic [1:0] CELL_EMPTY = 2'd0;
    localparam logic [1:0] CELL_P1    = 2'd1;
    localparam logic [1:0] CELL_P2    = 2'd2;

    localparam logic [3:0] POS_MIN   = 4'd1;
    localparam logic [3:0] POS_MAX   = 4'd9;
    localparam int         NUM_CELLS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_P1_TURN,
        ST_P2_TURN,
        ST_CHECK,
        ST_WIN,
        ST_DRAW
    } state_e;

    function automatic logic [1:0] other_player(input logic [1:0] p);
        return (p == CELL_P1) ? CELL_P2 : CELL_P1;
    endfunction

endpackage

// File: rtl/detect_win.sv
// Combinational three-in-a-row detector over the nine board cells.
module detect_win
    import ttt_pkg::*;
(
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    output logic       winner,
    output logic [1:0] who_win
);

    // Owner of a line when all three cells hold the same player, else empty.
    function automatic logic [1:0] line3(input logic [1:0] a, input logic [1:0] b,
                                         input logic [1:0] c);
        return (a != CELL_EMPTY && a == b && a == c) ? a : CELL_EMPTY;
    endfunction

    logic [1:0] line_owner [8];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        winner  = 1'b0;
        who_win = CELL_EMPTY;
        line_owner[0] = line3(pos1, pos2, pos3);
        line_owner[1] = line3(pos4, pos5, pos6);
        line_owner[2] = line3(pos7, pos8, pos9);
        line_owner[3] = line3(pos1, pos4, pos7);
        line_owner[4] = line3(pos2, pos5, pos8);
        line_owner[5] = line3(pos3, pos6, pos9);
        line_owner[6] = line3(pos1, pos5, pos9);
        line_owner[7] = line3(pos3, pos5, pos7);
        for (int i = 0; i < 8; i++) begin
            if (!winner && line_owner[i] != CELL_EMPTY) begin
                winner  = 1'b1;
                who_win = line_owner[i];
            end
        end
    end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Turn controller: owns the board, alternates players, validates moves and
// latches the win/draw outcome reported by detect_win.
module ttt_game_ctrl
    import ttt_pkg::*;
#(
    parameter int TURN_TIMEOUT = 0,
    parameter int TO_W         = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       move_valid,
    input  logic [3:0] move_pos,
    output logic       move_ready,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] turn,
    output logic       illegal,
    output logic       timeout,
    output logic       game_over,
    output logic       winner,
    output logic [1:0] who_win,
    output logic [3:0] move_count
);

    localparam bit            TO_ENABLE = (TURN_TIMEOUT > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TURN_TIMEOUT > 0) ? TURN_TIMEOUT - 1 : 0);

    state_e          state_q, state_d;
    logic [1:0]      board_q [NUM_CELLS];
    logic [1:0]      board_d [NUM_CELLS];
    logic [3:0]      mc_q, mc_d;
    logic [1:0]      mover_q, mover_d;
    logic [1:0]      who_q, who_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            illegal_q, illegal_d;
    logic            timeout_q, timeout_d;

    logic            dw_winner;
    logic [1:0]      dw_who;
    logic            in_turn;
    logic [1:0]      cur_player;
    logic            cell_free;
    logic            expire;

    detect_win u_detect_win (
        .pos1    (board_q[0]),
        .pos2    (board_q[1]),
        .pos3    (board_q[2]),
        .pos4    (board_q[3]),
        .pos5    (board_q[4]),
        .pos6    (board_q[5]),
        .pos7    (board_q[6]),
        .pos8    (board_q[7]),
        .pos9    (board_q[8]),
        .winner  (dw_winner),
        .who_win (dw_who)
    );

    assign in_turn    = (state_q == ST_P1_TURN) || (state_q == ST_P2_TURN);
    assign cur_player = (state_q == ST_P2_TURN) ? CELL_P2 : CELL_P1;
    assign expire     = TO_ENABLE && (cnt_q == TO_LAST);

    always_comb begin
        cell_free = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (move_pos == 4'(i + 1) && board_q[i] == CELL_EMPTY) cell_free = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        mc_d      = mc_q;
        mover_d   = mover_q;
        who_d     = who_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;

        if (start) begin
            for (int i = 0; i < NUM_CELLS; i++) board_d[i] = CELL_EMPTY;
            mc_d    = 4'd0;
            cnt_d   = '0;
            who_d   = CELL_EMPTY;
            state_d = ST_P1_TURN;
        end else begin
            unique case (state_q)
                ST_P1_TURN, ST_P2_TURN: begin
                    if (move_valid && move_pos >= POS_MIN && move_pos <= POS_MAX && cell_free) begin
                        for (int i = 0; i < NUM_CELLS; i++) begin
                            if (move_pos == 4'(i + 1)) board_d[i] = cur_player;
                        end
                        mc_d    = mc_q + 4'd1;
                        mover_d = cur_player;
                        cnt_d   = '0;
                        state_d = ST_CHECK;
                    end else begin
                        illegal_d = move_valid;
                        if (expire) begin
                            timeout_d = 1'b1;
                            cnt_d     = '0;
                            state_d   = (state_q == ST_P1_TURN) ? ST_P2_TURN : ST_P1_TURN;
                        end else begin
                            cnt_d = TO_ENABLE ? cnt_q + 1'b1 : '0;
                        end
                    end
                end
                ST_CHECK: begin
                    // detect_win is looking at the board that includes the move just made.
                    if (dw_winner) begin
                        who_d   = dw_who;
                        state_d = ST_WIN;
                    end else if (mc_q == 4'd9) begin
                        state_d = ST_DRAW;
                    end else begin
                        state_d = (other_player(mover_q) == CELL_P1) ? ST_P1_TURN : ST_P2_TURN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            // NOTE: the board is a small register array and is reset explicitly; IDLE must read empty.
            for (int i = 0; i < NUM_CELLS; i++) board_q[i] <= CELL_EMPTY;
            mc_q      <= 4'd0;
            mover_q   <= CELL_EMPTY;
            who_q     <= CELL_EMPTY;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            board_q   <= board_d;
            mc_q      <= mc_d;
            mover_q   <= mover_d;
            who_q     <= who_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        unique case (state_q)
            ST_P1_TURN: turn = CELL_P1;
            ST_P2_TURN: turn = CELL_P2;
            ST_CHECK:   turn = mover_q;
            default:    turn = CELL_EMPTY;
        endcase
    end

    assign move_ready = in_turn;
    assign game_over  = (state_q == ST_WIN) || (state_q == ST_DRAW);
    assign winner     = (state_q == ST_WIN);
    assign who_win    = (state_q == ST_WIN) ? who_q : CELL_EMPTY;
    assign move_count = mc_q;
    assign illegal    = illegal_q;
    assign timeout    = timeout_q;

    assign pos1 = board_q[0];
    assign pos2 = board_q[1];
    assign pos3 = board_q[2];
    assign pos4 = board_q[3];
    assign pos5 = board_q[4];
    assign pos6 = board_q[5];
    assign pos7 = board_q[6];
    assign pos8 = board_q[7];
    assign pos9 = board_q[8];

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Bench for ttt_game_ctrl: two instances (timeout off / timeout 8) driven by
// shared stimulus and compared every cycle against a rules-level game model.
module tb_ttt_game_ctrl;

    localparam int PH_IDLE  = 0;
    localparam int PH_TURN  = 1;
    localparam int PH_CHECK = 2;
    localparam int PH_WIN   = 3;
    localparam int PH_DRAW  = 4;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       move_valid;
    logic [3:0] move_pos;

    logic       o_ready   [2];
    logic [1:0] o_pos     [2][9];
    logic [1:0] o_turn    [2];
    logic       o_illegal [2];
    logic       o_timeout [2];
    logic       o_over    [2];
    logic       o_winner  [2];
    logic [1:0] o_who     [2];
    logic [3:0] o_mc      [2];

    int n_tests = 0;
    int n_fail  = 0;

    int m_board [2][9];
    int m_ph    [2];
    int m_cur   [2];
    int m_mover [2];
    int m_idle  [2];
    int m_mc    [2];
    int m_who   [2];
    bit m_ill   [2];
    bit m_to    [2];

    int win_lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    ttt_game_ctrl #(.TURN_TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid), .move_pos(move_pos),
        .move_ready(o_ready[0]),
        .pos1(o_pos[0][0]), .pos2(o_pos[0][1]), .pos3(o_pos[0][2]),
        .pos4(o_pos[0][3]), .pos5(o_pos[0][4]), .pos6(o_pos[0][5]),
        .pos7(o_pos[0][6]), .pos8(o_pos[0][7]), .pos9(o_pos[0][8]),
        .turn(o_turn[0]), .illegal(o_illegal[0]), .timeout(o_timeout[0]),
        .game_over(o_over[0]), .winner(o_winner[0]), .who_win(o_who[0]), .move_count(o_mc[0])
    );

    ttt_game_ctrl #(.TURN_TIMEOUT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .move_valid(move_valid), .move_pos(move_pos),
        .move_ready(o_ready[1]),
        .pos1(o_pos[1][0]), .pos2(o_pos[1][1]), .pos3(o_pos[1][2]),
        .pos4(o_pos[1][3]), .pos5(o_pos[1][4]), .pos6(o_pos[1][5]),
        .pos7(o_pos[1][6]), .pos8(o_pos[1][7]), .pos9(o_pos[1][8]),
        .turn(o_turn[1]), .illegal(o_illegal[1]), .timeout(o_timeout[1]),
        .game_over(o_over[1]), .winner(o_winner[1]), .who_win(o_who[1]), .move_count(o_mc[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < 9; c++) m_board[i][c] = 0;
            m_ph[i] = PH_IDLE; m_cur[i] = 1; m_mover[i] = 0; m_idle[i] = 0;
            m_mc[i] = 0; m_who[i] = 0; m_ill[i] = 0; m_to[i] = 0;
        end
    endtask

    function automatic int line_winner(input int i);
        for (int l = 0; l < 8; l++) begin
            int a = m_board[i][win_lines[l][0]];
            if (a != 0 && a == m_board[i][win_lines[l][1]] && a == m_board[i][win_lines[l][2]])
                return a;
        end
        return 0;
    endfunction

    task automatic model_step(input int i, input bit s, input bit mv, input int p);
        int limit = (i == 0) ? 0 : 8;
        int w;
        m_ill[i] = 0;
        m_to[i]  = 0;
        if (s) begin
            for (int c = 0; c < 9; c++) m_board[i][c] = 0;
            m_mc[i] = 0; m_idle[i] = 0; m_who[i] = 0;
            m_ph[i] = PH_TURN; m_cur[i] = 1;
        end else begin
            case (m_ph[i])
                PH_TURN: begin
                    if (mv && p >= 1 && p <= 9 && m_board[i][p-1] == 0) begin
                        m_board[i][p-1] = m_cur[i];
                        m_mc[i]++;
                        m_mover[i] = m_cur[i];
                        m_idle[i]  = 0;
                        m_ph[i]    = PH_CHECK;
                    end else begin
                        if (mv) m_ill[i] = 1;
                        if (limit > 0 && m_idle[i] + 1 == limit) begin
                            m_cur[i]  = 3 - m_cur[i];
                            m_to[i]   = 1;
                            m_idle[i] = 0;
                        end else begin
                            m_idle[i]++;
                        end
                    end
                end
                PH_CHECK: begin
                    w = line_winner(i);
                    if (w != 0) begin
                        m_ph[i] = PH_WIN; m_who[i] = w;
                    end else if (m_mc[i] == 9) begin
                        m_ph[i] = PH_DRAW;
                    end else begin
                        m_ph[i] = PH_TURN; m_cur[i] = 3 - m_mover[i];
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all(input int i);
        string pf = (i == 0) ? "t0" : "t8";
        int exp_turn;
        exp_turn = (m_ph[i] == PH_TURN) ? m_cur[i] : (m_ph[i] == PH_CHECK) ? m_mover[i] : 0;
        for (int c = 0; c < 9; c++)
            check($sformatf("%s pos%0d", pf, c + 1), 32'(o_pos[i][c]), 32'(m_board[i][c]));
        check({pf, " move_ready"}, 32'(o_ready[i]), 32'(m_ph[i] == PH_TURN));
        check({pf, " turn"}, 32'(o_turn[i]), 32'(exp_turn));
        check({pf, " illegal"}, 32'(o_illegal[i]), 32'(m_ill[i]));
        check({pf, " timeout"}, 32'(o_timeout[i]), 32'(m_to[i]));
        check({pf, " game_over"}, 32'(o_over[i]), 32'(m_ph[i] == PH_WIN || m_ph[i] == PH_DRAW));
        check({pf, " winner"}, 32'(o_winner[i]), 32'(m_ph[i] == PH_WIN));
        check({pf, " who_win"}, 32'(o_who[i]), 32'((m_ph[i] == PH_WIN) ? m_who[i] : 0));
        check({pf, " move_count"}, 32'(o_mc[i]), 32'(m_mc[i]));
    endtask

    task automatic step(input bit s, input bit mv, input int p);
        start      = s;
        move_valid = mv;
        move_pos   = 4'(p);
        @(posedge clk);
        model_step(0, s, mv, p);
        model_step(1, s, mv, p);
        #1;
        compare_all(0);
        compare_all(1);
    endtask

    task automatic play(input int p);
        step(0, 1, p);
        step(0, 0, 0);
    endtask

    initial begin
        int seq_draw [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
        int seq_win9 [9] = '{1, 2, 3, 5, 4, 6, 8, 9, 7};
        int mv_pct;

        rst_n = 1'b0; start = 1'b0; move_valid = 1'b0; move_pos = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all(0);
        compare_all(1);
        rst_n = 1'b1;
        step(0, 0, 0);
        step(0, 1, 5);

        step(1, 0, 0);
        check("start turn", 32'(o_turn[0]), 32'd1);
        check("start ready", 32'(o_ready[0]), 32'd1);

        foreach (seq_draw[k]) ; // keep arrays in scope for later use
        play(1); play(4); play(2); play(5); play(3);
        check("row win who", 32'(o_who[0]), 32'd1);
        check("row win count", 32'(o_mc[0]), 32'd5);
        step(0, 1, 7);

        step(1, 0, 0);
        play(5);
        step(0, 1, 5);
        check("dup cell pos5", 32'(o_pos[0][4]), 32'd1);
        step(0, 1, 0);
        step(0, 1, 12);
        check("illegal pulse", 32'(o_illegal[0]), 32'd1);
        step(0, 0, 0);
        check("turn held", 32'(o_turn[0]), 32'd2);

        step(1, 0, 0);
        for (int k = 0; k < 9; k++) play(seq_draw[k]);
        check("draw over", 32'(o_over[0]), 32'd1);
        check("draw winner", 32'(o_winner[0]), 32'd0);

        step(1, 0, 0);
        for (int k = 0; k < 9; k++) play(seq_win9[k]);
        check("win9 winner", 32'(o_winner[0]), 32'd1);
        check("win9 count", 32'(o_mc[0]), 32'd9);

        step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        step(1, 0, 0);
        repeat (7) step(0, 0, 0);
        step(0, 1, 5);
        check("expiry move no timeout", 32'(o_timeout[1]), 32'd0);
        step(0, 0, 0);

        step(0, 1, 1);
        step(0, 0, 0);
        step(1, 1, 3);
        check("start beats move pos3", 32'(o_pos[0][2]), 32'd0);

        step(0, 1, 6);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all(0);
        compare_all(1);
        #4 rst_n = 1'b1;
        step(0, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            bit s;
            bit mv;
            int p;
            mv_pct = (n < 1500) ? 60 : 15;
            s  = ($urandom_range(0, 39) == 0);
            mv = ($urandom_range(0, 99) < mv_pct);
            p  = ($urandom_range(0, 9) < 8) ? int'($urandom_range(1, 9)) : int'($urandom_range(0, 15));
            step(s, mv, p);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Sequential turn controller for the 3-in-a-row game. Owns the nine-cell board register, alternates turns between player 1 and player 2, accepts one move per turn through a valid/ready handshake and rejects illegal moves. Drives the existing combinational `detect_win` block from the board register and turns its result into a latched win/draw end-of-game status for the display and top level.

## Interface
Parameters:
- `TURN_TIMEOUT`, default 0: cycles a player may idle in a turn before the turn is forfeited; 0 disables the timeout.
- `TO_W`, default 32: width of the timeout counter; `TURN_TIMEOUT` must be < 2^TO_W.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `start`  in  1  level-sampled; clears board and begins new game (player 1 first).
- `move_valid`  in  1  move offered this cycle.
- `move_pos`  in  4  target cell, legal range 1..9 (row-major, matches pos1..pos9).
- `move_ready`  out  1  high only in P1_TURN/P2_TURN.
- `pos1`..`pos9`  out  2 each  board cells: 0 empty, 1 player 1, 2 player 2; 3 never driven.
- `turn`  out  2  player to move: 1 or 2, 0 when no game active.
- `illegal`  out  1  one-cycle pulse: offered move rejected.
- `timeout`  out  1  one-cycle pulse: turn forfeited by timeout.
- `game_over`  out  1  high in WIN or DRAW.
- `winner`  out  1  high in WIN.
- `who_win`  out  2  winning player (1/2) in WIN, else 0.
- `move_count`  out  4  moves placed this game, 0..9.

## Operation
- States: IDLE, P1_TURN, P2_TURN, CHECK, WIN, DRAW.
- IDLE: board cleared; waits for `start`.
- `start` high in any state: next edge clears board, `move_count`=0, timeout counter=0, state P1_TURN. `start` has priority over every other input in the same cycle.
- Move accepted when `move_valid && move_ready` and `move_pos` in 1..9 and that cell is 0: cell written with current player's code, `move_count`+1, remember mover, state CHECK.
- Illegal move (`move_pos` 0 or 10..15, or cell non-zero): `illegal` pulses next cycle, board/state/turn unchanged, timeout counter keeps running.
- CHECK (one cycle; `detect_win` sees the updated board): `winner` from detect_win -> WIN with `who_win` latched from detect_win; else `move_count`==9 -> DRAW; else other player's turn state. Win on the ninth move is WIN, not DRAW.
- WIN/DRAW: board, `who_win`, `move_count` frozen; `move_valid` ignored (ready low) until `start`.
- Timeout (`TURN_TIMEOUT`>0): counter increments each cycle in a turn state, cleared on entry to any turn state; when it reaches `TURN_TIMEOUT` with no accepted move that cycle, turn passes to other player, `timeout` pulses, board and `move_count` unchanged. An accepted move in the expiry cycle wins over timeout.
- `turn`: 1 in P1_TURN, 2 in P2_TURN, mover's code in CHECK, 0 in IDLE/WIN/DRAW.

## Timing
- Reset values: state IDLE, pos1..pos9=0, `turn`=0, `move_ready`=0, `illegal`=0, `timeout`=0, `game_over`=0, `winner`=0, `who_win`=0, `move_count`=0, timeout counter 0.
- Reset mid-game discards the game immediately (async); resumes in IDLE.
- Move accepted at edge N: cell visible after N; CHECK during cycle N..N+1; next turn/WIN/DRAW after edge N+1. `move_ready` low for that one CHECK cycle.
- `illegal`, `timeout` registered, exactly one cycle wide.
- `game_over`, `winner`, `who_win` registered from state; no combinational path from `move_*` to any output except via `move_ready` = f(state).

## Structure
- Package `ttt_pkg`: cell codes CELL_EMPTY=0, CELL_P1=1, CELL_P2=2; state enum type; legal position range constants.
- Sub-module: instantiate the existing `detect_win` once, fed from the board register; no new sub-module.

## Test plan
- Reset then `start`: `turn`=1, `move_ready`=1, all cells 0, `move_count`=0.
- P1 at 1, P2 at 4, P1 at 2, P2 at 5, P1 at 3 -> after CHECK: WIN, `who_win`=1, `winner`=1, `move_count`=5, ready low.
- P1 at 5 then P2 at 5 -> `illegal` one-cycle pulse, pos5 stays 1, `turn` stays 2; `move_pos`=0 and 12 also -> `illegal`.
- Full board sequence 1,2,3,5,4,6,8,7,9 (no line) -> DRAW, `winner`=0, `who_win`=0, `move_count`=9; variant finishing a line on move 9 -> WIN.
- `TURN_TIMEOUT`=8: idle 8 cycles in P1_TURN -> `timeout` pulse, `turn`=2, board unchanged; move in expiry cycle -> accepted, no timeout.
- `start` with `move_valid` same cycle mid-game -> board cleared, P1_TURN, move ignored; `rst_n` low mid-CHECK -> all outputs to reset values asynchronously.
